button_events: RTL
==================

# button_events

Press-event classifier placed directly downstream of the debounce stage. Takes the stable, debounced button level and emits single-cycle event pulses: press, release, single click, double click, and long press, plus an optional auto-repeat while the button is held. Its outputs drive the project's control logic (mode selection, counters) instead of raw button levels.

## Interface
- `LONG_TICKS`, 50_000_000: number of held cycles that qualifies a long press (1 s at 50 MHz). Must be ≥ 2.
- `DOUBLE_TICKS`, 12_500_000: window, in cycles after a short release, for a second press to count as a double click (250 ms). Must be ≥ 2.
- `REPEAT_TICKS`, 10_000_000: auto-repeat period while in long hold (200 ms). Used only with `BTN_REPEAT_EN`.
- `clk` input 1: board clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `btn` input 1: debounced button level, active-high. It is already synchronous to `clk`.
- `press` output 1: one-cycle pulse on the rising edge of `btn`.
- `release_ev` output 1: one-cycle pulse on the falling edge of `btn`.
- `single_click` output 1: one-cycle pulse when a short press is not followed by a second press within the window.
- `double_click` output 1: one-cycle pulse on the second press inside the window.
- `long_press` output 1: one-cycle pulse when the hold reaches `LONG_TICKS`.
- `repeat_ev` output 1: auto-repeat pulse. Tied to 0 without `BTN_REPEAT_EN`.
- `held` output 1: high while in the long-hold state.

## Operation
- Edge detection:
  - `btn_q` is a registered copy of `btn`.
  - rise = `btn & ~btn_q`; fall = `~btn & btn_q`.
  - `btn_q` resets to 1. A button held through reset therefore produces no press; only a release followed by a new press does.
- Reset values: every output is 0, state is IDLE, and `cnt` is 0.
- `press` and `release_ev` fire on every edge, independent of the FSM state.
- FSM states and transitions:
  - IDLE: on rise, go to PRESSED and set `cnt`=0.
  - PRESSED:
    - On fall (priority), go to WAIT_SECOND and set `cnt`=0.
    - Otherwise, if `cnt`==`LONG_TICKS`-1, pulse `long_press` and go to LONG_HELD.
    - Otherwise increment `cnt`.
  - LONG_HELD: `held`=1. On fall, go to IDLE. No click events are emitted for this press.
  - WAIT_SECOND:
    - On rise (priority), pulse `double_click` and go to SECOND_PRESS.
    - Otherwise, if `cnt`==`DOUBLE_TICKS`-1, pulse `single_click` and go to IDLE.
    - Otherwise increment `cnt`.
  - SECOND_PRESS: on fall, go to IDLE. There is no long-press detection on the second press.
- Counter:
  - One shared `cnt`, width `$clog2(max(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS))`, unsigned.
  - Compare by equality only; `cnt` is never allowed to wrap.
- A third press arriving during SECOND_PRESS or immediately after it starts a new sequence from IDLE.

## Timing
- Edge k is the first clock edge that samples `btn`=1 with `btn_q`=0.
- `press` is high for exactly one cycle following edge k. Latency is 1 clock from the `btn` change.
- Long press: if `btn` stays high through edge k+`LONG_TICKS`, `long_press` fires at edge k+`LONG_TICKS`.
- If the fall is sampled on that same edge, the fall wins: the press is treated as short and no long press is emitted.
- Fall sampled at edge m from PRESSED:
  - `release_ev` fires at edge m.
  - `single_click` fires at edge m+`DOUBLE_TICKS` if no rise is sampled on edges m+1 … m+`DOUBLE_TICKS`.
  - A rise sampled on edge m+`DOUBLE_TICKS` still yields `double_click`, and no `single_click`.
- At most one of `single_click`, `double_click`, `long_press` is high in any cycle.
- `press` may coincide with `double_click`.
- Reset asserted mid-sequence aborts the sequence: no pending click is emitted after reset.

## Configuration
- `BTN_REPEAT_EN` defined:
  - On entry to LONG_HELD, `cnt`=0.
  - `repeat_ev` pulses when `cnt`==`REPEAT_TICKS`-1; `cnt` then returns to 0 and repeats until the fall.
  - The first `repeat_ev` comes `REPEAT_TICKS` cycles after `long_press`.
- `BTN_REPEAT_EN` undefined: `repeat_ev` is constant 0 and no repeat counting logic is built. `REPEAT_TICKS` is ignored.

## Structure
- Shared package `button_pkg`: the state enum typedef (IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_PRESS) and the default tick constants for the 50 MHz board clock.
- One natural sub-module: `edge_detect`. It holds the `btn_q` register with reset value 1 and produces the rise and fall signals. Everything else lives in the top-level FSM.

## Test plan
All scenarios use `LONG_TICKS`=8, `DOUBLE_TICKS`=6, `REPEAT_TICKS`=4.
- Single click: `btn` high 3 cycles, then low → `press` at edge k, `release_ev` at edge k+3, `single_click` exactly at edge k+9, no other events.
- Double click: high 2, low 3, high 2, low → `double_click` coincides with the second `press`; no `single_click` ever.
- Long press: high 12 cycles → `long_press` at edge k+8, `held`=1 until the fall, then `release_ev` and no click.
- Boundary cases:
  - Fall sampled on edge k+8 → no `long_press`; `single_click` 6 edges after the fall.
  - Second rise exactly 6 edges after the fall → `double_click`, not `single_click`.
- Reset and repeat:
  - `btn` held high across `rst_n` deassertion → no `press`.
  - `rst_n` pulsed during WAIT_SECOND → no `single_click`.
  - With `BTN_REPEAT_EN`, a 20-cycle hold → `repeat_ev` at edges k+12 and k+16 (k+20 as well if the fall has not yet been sampled by that edge).

Source files
------------

// File: rtl/button_pkg.sv
// rtl/button_pkg.sv - shared state encoding and 50 MHz tick defaults for button_events
package button_pkg;

   typedef enum logic [2:0] {
      IDLE,
      PRESSED,
      LONG_HELD,
      WAIT_SECOND,
      SECOND_PRESS
   } state_t;

   localparam int DEF_LONG_TICKS   = 50_000_000;
   localparam int DEF_DOUBLE_TICKS = 12_500_000;
   localparam int DEF_REPEAT_TICKS = 10_000_000;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/edge_detect.sv
// rtl/edge_detect.sv - registered level copy and rise/fall strobes for the debounced button
module edge_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic rise_o,
   output logic fall_o
);

   logic btn_q;

   // Resets high so a button held through reset does not look like a fresh press.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         btn_q <= 1'b1;
      end else begin
         btn_q <= btn_i;
      end
   end

   assign rise_o = btn_i & ~btn_q;
   assign fall_o = ~btn_i & btn_q;

endmodule

// File: rtl/button_events.sv
// rtl/button_events.sv - press/release/click/double/long-press classifier; auto-repeat under BTN_REPEAT_EN
module button_events
   import button_pkg::*;
#(
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DOUBLE_TICKS = DEF_DOUBLE_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press,
   output logic release_ev,
   output logic single_click,
   output logic double_click,
   output logic long_press,
   output logic repeat_ev,
   output logic held
);

   localparam int CNT_W = $clog2(max3(LONG_TICKS, DOUBLE_TICKS, REPEAT_TICKS));
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DOUBLE_LAST = CNT_W'(DOUBLE_TICKS - 1);
`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

   logic rise;
   logic fall;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             press_q;
   logic             release_q;
   logic             single_q;
   logic             double_q;
   logic             long_q;
   logic             held_q;
`ifdef BTN_REPEAT_EN
   logic             repeat_q;
`endif

   edge_detect u_edge_detect (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn),
      .rise_o (rise),
      .fall_o (fall)
   );

   // Classifier FSM: one shared counter, equality compares only, all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         single_q  <= 1'b0;
         double_q  <= 1'b0;
         long_q    <= 1'b0;
         held_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
      end else begin
         press_q   <= rise;
         release_q <= fall;
         single_q  <= 1'b0;
         double_q  <= 1'b0;
         long_q    <= 1'b0;
`ifdef BTN_REPEAT_EN
         repeat_q  <= 1'b0;
`endif
         case (state_q)
            IDLE: begin
               if (rise) begin
                  state_q <= PRESSED;
                  cnt_q   <= '0;
               end
            end
            PRESSED: begin
               // A fall on the long-press edge wins: the press counts as short.
               if (fall) begin
                  state_q <= WAIT_SECOND;
                  cnt_q   <= '0;
               end else if (cnt_q == LONG_LAST) begin
                  long_q  <= 1'b1;
                  held_q  <= 1'b1;
                  state_q <= LONG_HELD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            LONG_HELD: begin
               if (fall) begin
                  held_q  <= 1'b0;
                  state_q <= IDLE;
               end
`ifdef BTN_REPEAT_EN
               else if (cnt_q == REPEAT_LAST) begin
                  repeat_q <= 1'b1;
                  cnt_q    <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
`endif
            end
            WAIT_SECOND: begin
               // A rise on the window's last edge still counts as a double click.
               if (rise) begin
                  double_q <= 1'b1;
                  state_q  <= SECOND_PRESS;
               end else if (cnt_q == DOUBLE_LAST) begin
                  single_q <= 1'b1;
                  state_q  <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            SECOND_PRESS: begin
               if (fall) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign press        = press_q;
   assign release_ev   = release_q;
   assign single_click = single_q;
   assign double_click = double_q;
   assign long_press   = long_q;
   assign held         = held_q;
`ifdef BTN_REPEAT_EN
   assign repeat_ev    = repeat_q;
`else
   assign repeat_ev    = 1'b0;
`endif

endmodule
